counter_updown_mod: RTL and testbench

//  Parametrised modulo-N up/down counter; next generation of the team's 4-bit free-running counter.

---
 rtl/counter_pkg.sv | 20 ++
 rtl/counter_prescaler.sv | 33 +++
 rtl/counter_updown_mod.sv | 88 ++++++++
 tb/tb_counter_updown_mod.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/counter_pkg.sv
// Shared constants and helpers for the counter family (direction encoding, clog2).
package counter_pkg;

  localparam logic CNT_DOWN = 1'b0;
  localparam logic CNT_UP   = 1'b1;

  // Ceiling log2; clog2(1) == 0, callers clamp register widths to at least 1 bit.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    int unsigned rem;
    result = 0;
    rem    = (value > 0) ? value - 1 : 0;
    while (rem > 0) begin
      result = result + 1;
      rem    = rem >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/counter_prescaler.sv
// Divides enabled cycles by PRESCALE: tick fires on the last phase of each period.
module counter_prescaler
  import counter_pkg::*;
#(
  parameter int PRESCALE = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic restart,
  output logic tick
);

  localparam int PW = (PRESCALE > 1) ? int'(clog2(PRESCALE)) : 1;
  localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] phase;

  // PRESCALE==1 keeps phase pinned at 0, so tick degenerates to en.
  assign tick = en && (phase == LAST);

  // NOTE: reset is sampled inside the clocked block (synchronous) and all state uses <=.
  always_ff @(posedge clk) begin
    if (!rst) begin
      phase <= '0;
    end else if (restart) begin
      phase <= '0;
    end else if (en) begin
      phase <= (phase == LAST) ? '0 : phase + 1'b1;
    end
  end

endmodule

// File: rtl/counter_updown_mod.sv
// Modulo-MODULUS up/down counter with prescaler, clear/load and terminal-count pulse.
// Optional saturation mode (ports sat/sat_hit) is built when COUNTER_SAT_EN is defined.
module counter_updown_mod
  import counter_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int MODULUS  = 256,
  parameter int PRESCALE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up_dn,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
`ifdef COUNTER_SAT_EN
  input  logic             sat,
  output logic             sat_hit,
`endif
  output logic [WIDTH-1:0] count,
  output logic             tc
);

  if (MODULUS < 2 || MODULUS > (2 ** WIDTH)) begin : g_bad_modulus
    $error("counter_updown_mod: MODULUS must be in 2..2**WIDTH");
  end
  if (PRESCALE < 1) begin : g_bad_prescale
    $error("counter_updown_mod: PRESCALE must be >= 1");
  end

  localparam logic [WIDTH-1:0] MAX = WIDTH'(MODULUS - 1);

  logic             tick;
  logic             at_limit;
  logic             blocked;
  logic [WIDTH-1:0] stepped;

  counter_prescaler #(
    .PRESCALE (PRESCALE)
  ) u_prescaler (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .restart (clr | load),
    .tick    (tick)
  );

  // Wrap is detected by explicit compare so non-power-of-two moduli work.
  assign at_limit = (up_dn == CNT_UP) ? (count == MAX) : (count == '0);
  assign stepped  = (up_dn == CNT_UP) ? (at_limit ? '0  : count + 1'b1)
                                      : (at_limit ? MAX : count - 1'b1);

`ifdef COUNTER_SAT_EN
  assign blocked = sat && at_limit;

  always_ff @(posedge clk) begin
    if (!rst) begin
      sat_hit <= 1'b0;
    end else if (clr || load) begin
      sat_hit <= 1'b0;
    end else if (tick && blocked) begin
      sat_hit <= 1'b1;
    end
  end
`else
  assign blocked = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      count <= '0;
      tc    <= 1'b0;
    end else if (clr) begin
      count <= '0;
      tc    <= 1'b0;
    end else if (load) begin
      count <= (load_val > MAX) ? MAX : load_val;
      tc    <= 1'b0;
    end else if (tick && !blocked) begin
      count <= stepped;
      tc    <= at_limit;
    end else begin
      tc    <= 1'b0;
    end
  end

endmodule

// File: tb/tb_counter_updown_mod.sv
// Directed bench: WIDTH=4/MODULUS=10 counters at PRESCALE 1 and 3 (saturation when COUNTER_SAT_EN).
module tb_counter_updown_mod;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  // PRESCALE=1 instance
  logic       rst, en, up_dn, clr, load;
  logic [3:0] load_val, count;
  logic       tc;
`ifdef COUNTER_SAT_EN
  logic       sat, sat_hit;
`endif

  // PRESCALE=3 instance
  logic       p_rst, p_en, p_up_dn, p_clr, p_load;
  logic [3:0] p_load_val, p_count;
  logic       p_tc;
`ifdef COUNTER_SAT_EN
  logic       p_sat, p_sat_hit;
`endif

  int total = 0;
  int bad   = 0;

  counter_updown_mod #(.WIDTH(4), .MODULUS(10), .PRESCALE(1)) u_dut (
    .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .clr(clr), .load(load),
    .load_val(load_val),
`ifdef COUNTER_SAT_EN
    .sat(sat), .sat_hit(sat_hit),
`endif
    .count(count), .tc(tc)
  );

  counter_updown_mod #(.WIDTH(4), .MODULUS(10), .PRESCALE(3)) u_pre (
    .clk(clk), .rst(p_rst), .en(p_en), .up_dn(p_up_dn), .clr(p_clr), .load(p_load),
    .load_val(p_load_val),
`ifdef COUNTER_SAT_EN
    .sat(p_sat), .sat_hit(p_sat_hit),
`endif
    .count(p_count), .tc(p_tc)
  );

  typedef struct {
    logic       rst, en, up_dn, clr, load;
    logic [3:0] load_val;
    logic [3:0] exp_count;
    logic       exp_tc;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic r, input logic e, input logic u, input logic c,
                              input logic l, input logic [3:0] lv, input logic [3:0] ec,
                              input logic et);
    vec_t v;
    v.rst = r; v.en = e; v.up_dn = u; v.clr = c; v.load = l;
    v.load_val = lv; v.exp_count = ec; v.exp_tc = et;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic p_drive(input logic r, input logic e, input logic u, input logic c,
                         input logic l, input logic [3:0] lv);
    p_rst = r; p_en = e; p_up_dn = u; p_clr = c; p_load = l; p_load_val = lv;
  endtask

  task automatic p_expect(input string name, input logic [3:0] ec, input logic et);
    step();
    check({name, " count"}, 32'(p_count), 32'(ec));
    check({name, " tc"},    32'(p_tc),    32'(et));
  endtask

  initial begin
    // reset two cycles, then count up through the wrap
    vecs.push_back(mk(0, 1, 1, 0, 0, 4'd0, 4'd0, 0));
    vecs.push_back(mk(0, 1, 1, 0, 0, 4'd0, 4'd0, 0));
    for (int i = 1; i <= 10; i++)
      vecs.push_back(mk(1, 1, 1, 0, 0, 4'd0, 4'(i % 10), (i == 10)));
    // count down across the zero wrap
    vecs.push_back(mk(1, 1, 0, 0, 0, 4'd0, 4'd9, 1));
    vecs.push_back(mk(1, 1, 0, 0, 0, 4'd0, 4'd8, 0));
    vecs.push_back(mk(1, 1, 0, 0, 0, 4'd0, 4'd7, 0));
    // load (with en high), clamped load, clr beats load
    vecs.push_back(mk(1, 1, 0, 0, 1, 4'd7,  4'd7, 0));
    vecs.push_back(mk(1, 1, 0, 0, 1, 4'd12, 4'd9, 0));
    vecs.push_back(mk(1, 1, 0, 1, 1, 4'd5,  4'd0, 0));
    // hold, direction change without implied wrap
    vecs.push_back(mk(1, 0, 1, 0, 0, 4'd0, 4'd0, 0));
    vecs.push_back(mk(1, 1, 1, 0, 0, 4'd0, 4'd1, 0));
    vecs.push_back(mk(1, 1, 0, 0, 0, 4'd0, 4'd0, 0));
    vecs.push_back(mk(1, 1, 0, 0, 0, 4'd0, 4'd9, 1));
    vecs.push_back(mk(1, 1, 0, 1, 0, 4'd0, 4'd0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 1, 4'd15, 4'd9, 0));
    vecs.push_back(mk(1, 1, 1, 0, 0, 4'd0, 4'd0, 1));
    vecs.push_back(mk(1, 0, 1, 0, 0, 4'd0, 4'd0, 0));

`ifdef COUNTER_SAT_EN
    sat = 1'b0; p_sat = 1'b0;
`endif
    p_drive(0, 0, 1, 0, 0, 4'd0);

    foreach (vecs[i]) begin
      rst = vecs[i].rst; en = vecs[i].en; up_dn = vecs[i].up_dn;
      clr = vecs[i].clr; load = vecs[i].load; load_val = vecs[i].load_val;
      step();
      check($sformatf("vec%0d count", i), 32'(count), 32'(vecs[i].exp_count));
      check($sformatf("vec%0d tc", i),    32'(tc),     32'(vecs[i].exp_tc));
    end
    en = 1'b0; clr = 1'b0; load = 1'b0;

    // prescaler: steps every third enabled cycle
    p_drive(0, 1, 1, 0, 0, 4'd0);
    p_expect("pre_rst", 4'd0, 0);
    p_drive(1, 1, 1, 0, 0, 4'd0);
    p_expect("pre_a1", 4'd0, 0);
    p_expect("pre_a2", 4'd0, 0);
    p_expect("pre_a3", 4'd1, 0);
    p_expect("pre_b1", 4'd1, 0);
    p_expect("pre_b2", 4'd1, 0);
    p_expect("pre_b3", 4'd2, 0);
    p_expect("pre_c1", 4'd2, 0);
    // en low mid-phase: phase and count hold
    p_drive(1, 0, 1, 0, 0, 4'd0);
    p_expect("pre_hold1", 4'd2, 0);
    p_expect("pre_hold2", 4'd2, 0);
    p_drive(1, 1, 1, 0, 0, 4'd0);
    p_expect("pre_c2", 4'd2, 0);
    p_expect("pre_c3", 4'd3, 0);

    // wrap under prescaling: tc is a single-cycle pulse
    p_drive(1, 1, 1, 0, 1, 4'd9);
    p_expect("pre_load9", 4'd9, 0);
    p_drive(1, 1, 1, 0, 0, 4'd0);
    p_expect("pre_w1", 4'd9, 0);
    p_expect("pre_w2", 4'd9, 0);
    p_expect("pre_w3", 4'd0, 1);
    p_expect("pre_w4", 4'd0, 0);

    // reset mid-phase restarts a full prescale period
    p_drive(1, 1, 1, 0, 1, 4'd5);
    p_expect("pre_load5", 4'd5, 0);
    p_drive(1, 1, 1, 0, 0, 4'd0);
    p_expect("pre_mid", 4'd5, 0);
    p_drive(0, 1, 1, 0, 0, 4'd0);
    p_expect("pre_rst2", 4'd0, 0);
    p_drive(1, 1, 1, 0, 0, 4'd0);
    p_expect("pre_r1", 4'd0, 0);
    p_expect("pre_r2", 4'd0, 0);
    p_expect("pre_r3", 4'd1, 0);

`ifdef COUNTER_SAT_EN
    // saturation at the top, sticky sat_hit, cleared by clr
    sat = 1'b1; rst = 1'b1; en = 1'b1; up_dn = 1'b1; load = 1'b1; load_val = 4'd8;
    step();
    load = 1'b0;
    step();
    check("sat_up1 count", 32'(count), 32'd9);
    check("sat_up1 hit",   32'(sat_hit), 32'd0);
    step();
    check("sat_up2 count", 32'(count), 32'd9);
    check("sat_up2 hit",   32'(sat_hit), 32'd1);
    check("sat_up2 tc",    32'(tc), 32'd0);
    step();
    check("sat_up3 count", 32'(count), 32'd9);
    check("sat_up3 hit",   32'(sat_hit), 32'd1);
    check("sat_up3 tc",    32'(tc), 32'd0);
    clr = 1'b1;
    step();
    check("sat_clr count", 32'(count), 32'd0);
    check("sat_clr hit",   32'(sat_hit), 32'd0);
    clr = 1'b0; up_dn = 1'b0;
    step();
    check("sat_dn count", 32'(count), 32'd0);
    check("sat_dn hit",   32'(sat_hit), 32'd1);
    check("sat_dn tc",    32'(tc), 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
